// File: rtl/pixel_readout_collector_if.sv
// Stream bundle between PIXEL_TOP, the readout collector and the downstream pixel consumer.
// The collector sits on the slave side: it samples the word strobe/bus and the consumer's ready,
// and drives the per-pixel stream plus the status outputs.
interface pixel_readout_collector_if #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8
);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                                        DATA_OUT_CLK;
  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_IN;
  logic                                        PIXEL_READY;
  logic                                        PIXEL_VALID;
  logic [BIT_DEPTH-1:0]                        PIXEL_DATA;
  logic [XW-1:0]                               PIXEL_X;
  logic [YW-1:0]                               PIXEL_Y;
  logic                                        PIXEL_SOF;
  logic                                        PIXEL_EOL;
  logic                                        PIXEL_EOF;
  logic                                        OVERFLOW;
  logic [15:0]                                 FRAME_COUNT;

  // Source of words and sink of pixels (PIXEL_TOP plus downstream consumer, or a testbench).
  modport master (
    output DATA_OUT_CLK, DATA_IN, PIXEL_READY,
    input  PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y,
    input  PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, OVERFLOW, FRAME_COUNT
  );

  // The collector itself.
  modport slave (
    input  DATA_OUT_CLK, DATA_IN, PIXEL_READY,
    output PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y,
    output PIXEL_SOF, PIXEL_EOL, PIXEL_EOF, OVERFLOW, FRAME_COUNT
  );
endinterface

// File: rtl/pixel_readout_collector.sv
// Pixel readout collector.
// Catches each rising edge of the PIXEL_TOP word strobe, stores the bus word together with its
// position inside the frame in a small FIFO, then splits every word into single pixels on a
// valid/ready stream annotated with X/Y and start/end-of-line/frame markers.
// The word strobe is generated from the system clock, so it is edge-detected rather than
// used as a clock.
module pixel_readout_collector #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int FIFO_DEPTH             = 4
) (
  input logic                      i_SYSTEM_CLK,
  input logic                      i_SYSTEM_RESET,
  pixel_readout_collector_if.slave io_bus
);

  localparam int BUS_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int WORDS = (WIDTH * HEIGHT) / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW    = (OUTPUT_BUS_PIXEL_WIDTH > 1) ? $clog2(OUTPUT_BUS_PIXEL_WIDTH) : 1;
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Strobe edge detection and frame word position of the next incoming word.
  logic                 r_strbQ;
  logic [IW-1:0]        r_inIdx;

  // Word FIFO: payload and word position stored side by side.
  logic [BUS_W-1:0]     r_memData [FIFO_DEPTH];
  logic [IW-1:0]        r_memIdx  [FIFO_DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  // Serialiser: the word currently being split and the lane being presented.
  state_t               r_state;
  state_t               w_nextState;
  logic [BUS_W-1:0]     r_word;
  logic [IW-1:0]        r_wordIdx;
  logic [LW-1:0]        r_lane;
  logic [15:0]          r_frameCount;

  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pushAccept;
  logic                 w_pop;
  logic                 w_laneInc;
  logic                 w_valid;
  logic                 w_handshake;
  logic                 w_lastLane;
  logic [31:0]          w_pixIdx;
  logic [XW-1:0]        w_x;
  logic [YW-1:0]        w_y;
  logic [BIT_DEPTH-1:0] w_data;
  logic                 w_sof;
  logic                 w_eol;
  logic                 w_eof;

  // A word arrives on the cycle where the strobe is high but was low one cycle earlier.
  assign w_push     = io_bus.DATA_OUT_CLK && !r_strbQ;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands then.
  assign w_pushAccept = w_push && (!w_full || w_pop);
  assign w_lastLane = (32'(r_lane) == OUTPUT_BUS_PIXEL_WIDTH - 1);

  // Strobe history and the running word position; the position advances even for dropped
  // words so later words keep the coordinates they would have had.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (!i_SYSTEM_RESET) begin
      r_strbQ <= 1'b0;
      r_inIdx <= '0;
    end else begin
      r_strbQ <= io_bus.DATA_OUT_CLK;
      if (w_push) begin
        if (32'(r_inIdx) == WORDS - 1) begin
          r_inIdx <= '0;
        end else begin
          r_inIdx <= r_inIdx + IW'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers and count define what is valid.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (w_pushAccept) begin
      r_memData[r_wrPtr] <= io_bus.DATA_IN;
      r_memIdx[r_wrPtr]  <= r_inIdx;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (!i_SYSTEM_RESET) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_pushAccept && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_pushAccept && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_push && !w_pushAccept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serialiser state register.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (!i_SYSTEM_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Serialiser next state: leave SEND only when the final lane is taken and nothing is queued.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_nextState = ST_SEND;
        end
      end
      ST_SEND: begin
        if (io_bus.PIXEL_READY && w_lastLane && w_empty) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Serialiser outputs: when to pop the FIFO head and when to step to the next lane.
  always_comb begin
    w_valid     = 1'b0;
    w_handshake = 1'b0;
    w_pop       = 1'b0;
    w_laneInc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop = !w_empty;
      end
      ST_SEND: begin
        w_valid     = 1'b1;
        w_handshake = io_bus.PIXEL_READY;
        if (w_handshake) begin
          if (!w_lastLane) begin
            w_laneInc = 1'b1;
          end else begin
            w_pop = !w_empty;
          end
        end
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  // Word register: load the FIFO head on a pop, otherwise step lanes on accepted pixels.
  // Everything shown on the stream comes from here, so it holds still under backpressure.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (!i_SYSTEM_RESET) begin
      r_word    <= '0;
      r_wordIdx <= '0;
      r_lane    <= '0;
    end else if (w_pop) begin
      r_word    <= r_memData[r_rdPtr];
      r_wordIdx <= r_memIdx[r_rdPtr];
      r_lane    <= '0;
    end else if (w_laneInc) begin
      r_lane <= r_lane + LW'(1);
    end
  end

  // Pixel payload and coordinates derived from the word position and lane.
  always_comb begin
    w_pixIdx = 32'(r_wordIdx) * OUTPUT_BUS_PIXEL_WIDTH + 32'(r_lane);
    w_x      = XW'(w_pixIdx % WIDTH);
    w_y      = YW'(w_pixIdx / WIDTH);
    w_data   = r_word[32'(r_lane) * BIT_DEPTH +: BIT_DEPTH];
  end

  // Frame markers only assert alongside a valid pixel so they read zero while idle.
  always_comb begin
    w_sof = w_valid && (w_x == '0) && (w_y == '0);
    w_eol = w_valid && (32'(w_x) == WIDTH - 1);
    w_eof = w_eol && (32'(w_y) == HEIGHT - 1);
  end

  // Completed-frame counter, bumped when the last pixel of a frame is accepted.
  always_ff @(posedge i_SYSTEM_CLK) begin
    if (!i_SYSTEM_RESET) begin
      r_frameCount <= '0;
    end else if (w_handshake && w_eof) begin
      r_frameCount <= r_frameCount + 16'd1;
    end
  end

  assign io_bus.PIXEL_VALID = w_valid;
  assign io_bus.PIXEL_DATA  = w_data;
  assign io_bus.PIXEL_X     = w_x;
  assign io_bus.PIXEL_Y     = w_y;
  assign io_bus.PIXEL_SOF   = w_sof;
  assign io_bus.PIXEL_EOL   = w_eol;
  assign io_bus.PIXEL_EOF   = w_eof;
  assign io_bus.OVERFLOW    = r_overflow;
  assign io_bus.FRAME_COUNT = r_frameCount;

endmodule

// File: tb/tb_pixel_readout_collector.sv
// Testbench for pixel_readout_collector.
// A frame-level reference model turns every word strobe into the list of pixels it should
// produce (payload, coordinates, markers), tracks drops and completed frames, and each
// scenario task compares the observed pixel stream against that list.
module tb_pixel_readout_collector;

  localparam int W     = 2;
  localparam int H     = 2;
  localparam int OBPW  = 2;
  localparam int BD    = 8;
  localparam int FD    = 4;
  localparam int WORDS = (W * H) / OBPW;
  localparam int XW    = 1;
  localparam int YW    = 1;

  typedef struct packed {
    logic [BD-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } pix_t;

  logic systemClk = 1'b0;
  logic systemReset;

  pixel_readout_collector_if #(
    .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(OBPW), .BIT_DEPTH(BD)
  ) pif ();

  pixel_readout_collector #(
    .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(OBPW), .BIT_DEPTH(BD), .FIFO_DEPTH(FD)
  ) dut (
    .i_SYSTEM_CLK   (systemClk),
    .i_SYSTEM_RESET (systemReset),
    .io_bus         (pif)
  );

  always #5 systemClk = ~systemClk;

  pix_t expQ[$];
  pix_t obsQ[$];
  int   tests = 0;
  int   fails = 0;
  int   strobeCount;
  int   acceptedWords;
  int   consumedPixels;
  int   expFrames;
  logic expOverflow;

  // Record every pixel accepted by the consumer; sampled on the falling edge, half a cycle
  // before the rising edge that completes the handshake.
  always @(negedge systemClk) begin
    if (systemReset === 1'b1 && pif.PIXEL_VALID === 1'b1 && pif.PIXEL_READY === 1'b1) begin
      obsQ.push_back(pix_t'({pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y,
                             pif.PIXEL_SOF, pif.PIXEL_EOL, pif.PIXEL_EOF}));
      consumedPixels++;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge systemClk);
    #1;
  endtask

  task automatic clearModel();
    expQ.delete();
    obsQ.delete();
    strobeCount    = 0;
    acceptedWords  = 0;
    consumedPixels = 0;
    expFrames      = 0;
    expOverflow    = 1'b0;
  endtask

  // Reference model for one strobe: words cycle through frame positions 0..WORDS-1 and the
  // collector can hold FD queued words plus the one being split.
  task automatic modelPush(input logic [OBPW*BD-1:0] data);
    int   k;
    int   p;
    pix_t e;
    k = strobeCount % WORDS;
    strobeCount++;
    if (acceptedWords - consumedPixels / OBPW < FD + 1) begin
      acceptedWords++;
      for (int l = 0; l < OBPW; l++) begin
        p      = k * OBPW + l;
        e.data = data[l*BD +: BD];
        e.x    = XW'(p % W);
        e.y    = YW'(p / W);
        e.sof  = (p == 0);
        e.eol  = ((p % W) == W - 1);
        e.eof  = (p == W * H - 1);
        expQ.push_back(e);
      end
      if (k == WORDS - 1) expFrames++;
    end else begin
      expOverflow = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [OBPW*BD-1:0] data, input int lowCycles);
    modelPush(data);
    pif.DATA_IN      = data;
    pif.DATA_OUT_CLK = 1'b1;
    tick();
    pif.DATA_OUT_CLK = 1'b0;
    repeat (lowCycles) tick();
  endtask

  task automatic resetDut();
    systemReset      = 1'b0;
    pif.DATA_OUT_CLK = 1'b0;
    pif.DATA_IN      = '0;
    pif.PIXEL_READY  = 1'b0;
    tick();
    tick();
    clearModel();
    systemReset = 1'b1;
  endtask

  task automatic waitDrain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obsQ.size() >= expQ.size() && pif.PIXEL_VALID === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    resetDut();
    tests++;
    if ({pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_stream: valid/data/x/y got %h expected 0",
               {pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y});
    end
    tests++;
    if ({pif.PIXEL_SOF, pif.PIXEL_EOL, pif.PIXEL_EOF} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_markers: got %b expected 000",
               {pif.PIXEL_SOF, pif.PIXEL_EOL, pif.PIXEL_EOF});
    end
    tests++;
    if (pif.OVERFLOW !== 1'b0 || pif.FRAME_COUNT !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_status: overflow %b frames %0d expected 0 and 0",
               pif.OVERFLOW, pif.FRAME_COUNT);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    resetDut();
    pif.PIXEL_READY  = 1'b1;
    modelPush(16'h2211);
    pif.DATA_IN      = 16'h2211;
    pif.DATA_OUT_CLK = 1'b1;
    tick();
    tests++;
    if (pif.PIXEL_VALID !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_latency_n1: valid %b expected 0", pif.PIXEL_VALID);
    end
    pif.DATA_OUT_CLK = 1'b0;
    tick();
    tests++;
    if (pif.PIXEL_VALID !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_latency_n2: valid %b expected 1", pif.PIXEL_VALID);
    end
    repeat (6) tick();
    applyStimulus(16'h4433, 2);
    waitDrain(100, ok);
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL basic_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL basic_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    tests++;
    if (pif.FRAME_COUNT !== 16'(expFrames)) begin
      fails++;
      $display("[TB] FAIL basic_frames: got %0d expected %0d", pif.FRAME_COUNT, expFrames);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    resetDut();
    pif.PIXEL_READY = 1'b0;
    applyStimulus(16'h0100, 1);
    applyStimulus(16'h0302, 1);
    applyStimulus(16'h0504, 1);
    applyStimulus(16'h0706, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y,
           pif.PIXEL_SOF, pif.PIXEL_EOL, pif.PIXEL_EOF} !== {1'b1, expQ[0]}) begin
        fails++;
        $display("[TB] FAIL hold[%0d]: got %h expected %h", i,
                 {pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y,
                  pif.PIXEL_SOF, pif.PIXEL_EOL, pif.PIXEL_EOF}, {1'b1, expQ[0]});
      end
    end
    pif.PIXEL_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (pif.PIXEL_VALID !== 1'b1) begin
        fails++;
        $display("[TB] FAIL no_bubble[%0d]: valid %b expected 1", i, pif.PIXEL_VALID);
      end
      tick();
    end
    tests++;
    if (pif.PIXEL_VALID !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drained_idle: valid %b expected 0", pif.PIXEL_VALID);
    end
    waitDrain(50, ok);
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL bp_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL bp_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    tests++;
    if (pif.FRAME_COUNT !== 16'(expFrames)) begin
      fails++;
      $display("[TB] FAIL bp_frames: got %0d expected %0d", pif.FRAME_COUNT, expFrames);
    end
  endtask

  task automatic test_overflow();
    bit ok1;
    bit ok2;
    resetDut();
    pif.PIXEL_READY = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(16'($urandom), 1);
    tests++;
    if (pif.OVERFLOW !== expOverflow) begin
      fails++;
      $display("[TB] FAIL overflow_early: got %b expected %b", pif.OVERFLOW, expOverflow);
    end
    applyStimulus(16'($urandom), 2);
    tests++;
    if (pif.OVERFLOW !== expOverflow) begin
      fails++;
      $display("[TB] FAIL overflow_set: got %b expected %b", pif.OVERFLOW, expOverflow);
    end
    pif.PIXEL_READY = 1'b1;
    waitDrain(100, ok1);
    applyStimulus(16'($urandom), 2);
    waitDrain(100, ok2);
    tests++;
    if (!ok1 || !ok2 || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL ovf_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL ovf_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    tests++;
    if (pif.OVERFLOW !== expOverflow || pif.FRAME_COUNT !== 16'(expFrames)) begin
      fails++;
      $display("[TB] FAIL ovf_status: overflow %b frames %0d expected %b and %0d",
               pif.OVERFLOW, pif.FRAME_COUNT, expOverflow, expFrames);
    end
  endtask

  task automatic test_held_strobe();
    bit ok;
    resetDut();
    pif.PIXEL_READY  = 1'b1;
    modelPush(16'h5A3C);
    pif.DATA_IN      = 16'h5A3C;
    pif.DATA_OUT_CLK = 1'b1;
    repeat (10) tick();
    pif.DATA_OUT_CLK = 1'b0;
    waitDrain(50, ok);
    repeat (5) tick();
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL held_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL held_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    resetDut();
    for (int c = 0; c < 40; c++) begin
      pif.PIXEL_READY = (c % 2 == 1);
      if (c == 0 || c == 8) begin
        pif.DATA_IN      = (c == 0) ? 16'h2211 : 16'h4433;
        pif.DATA_OUT_CLK = 1'b1;
        modelPush(pif.DATA_IN);
      end else begin
        pif.DATA_OUT_CLK = 1'b0;
      end
      tick();
    end
    pif.PIXEL_READY = 1'b1;
    waitDrain(50, ok);
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL toggle_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL toggle_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    resetDut();
    pif.PIXEL_READY = 1'b0;
    applyStimulus(16'hBBAA, 3);
    tests++;
    if (pif.PIXEL_VALID !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_pre: valid %b expected 1", pif.PIXEL_VALID);
    end
    systemReset = 1'b0;
    tick();
    tests++;
    if ({pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y, pif.PIXEL_SOF,
         pif.PIXEL_EOL, pif.PIXEL_EOF, pif.OVERFLOW, pif.FRAME_COUNT} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {pif.PIXEL_VALID, pif.PIXEL_DATA, pif.PIXEL_X, pif.PIXEL_Y, pif.PIXEL_SOF,
                pif.PIXEL_EOL, pif.PIXEL_EOF, pif.OVERFLOW, pif.FRAME_COUNT});
    end
    clearModel();
    systemReset     = 1'b1;
    pif.PIXEL_READY = 1'b1;
    applyStimulus(16'hDDCC, 2);
    waitDrain(50, ok);
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL midreset_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL midreset_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_random();
    bit   ok;
    bit   high;
    int   sent;
    logic [OBPW*BD-1:0] data;
    resetDut();
    high = 1'b0;
    sent = 0;
    for (int c = 0; c < 3000 && sent < 40; c++) begin
      pif.PIXEL_READY = ($urandom_range(0, 9) < 7);
      if (high) begin
        pif.DATA_OUT_CLK = 1'b0;
        high             = 1'b0;
      end else if ((acceptedWords - consumedPixels / OBPW) <= 2 && $urandom_range(0, 2) == 0) begin
        data             = OBPW*BD'($urandom);
        pif.DATA_IN      = data;
        pif.DATA_OUT_CLK = 1'b1;
        modelPush(data);
        high = 1'b1;
        sent++;
      end
      tick();
    end
    pif.DATA_OUT_CLK = 1'b0;
    pif.PIXEL_READY  = 1'b1;
    waitDrain(200, ok);
    tests++;
    if (!ok || obsQ.size() != expQ.size()) begin
      fails++;
      $display("[TB] FAIL rand_count: got %0d pixels expected %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      tests++;
      if (obsQ[i] !== expQ[i]) begin
        fails++;
        $display("[TB] FAIL rand_pixel[%0d]: got %h expected %h", i, obsQ[i], expQ[i]);
      end
    end
    tests++;
    if (pif.FRAME_COUNT !== 16'(expFrames) || pif.OVERFLOW !== expOverflow) begin
      fails++;
      $display("[TB] FAIL rand_status: frames %0d overflow %b expected %0d and %b",
               pif.FRAME_COUNT, pif.OVERFLOW, expFrames, expOverflow);
    end
  endtask

  // Scenario sequence.
  initial begin
    systemReset      = 1'b0;
    pif.DATA_OUT_CLK = 1'b0;
    pif.DATA_IN      = '0;
    pif.PIXEL_READY  = 1'b0;
    clearModel();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overflow();
    test_held_strobe();
    test_ready_toggle();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
